// File: rtl/data_mem_mmio_if.sv
// Load/store bus between the MEM stage and the data memory.
// The core drives address, store data and write strobe; memory returns load data.
interface data_mem_mmio_if;
    logic        memwrite;
    logic [31:0] addr;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (output memwrite, addr, writedata, input readdata);
    modport slave  (input memwrite, addr, writedata, output readdata);
endinterface

// File: rtl/data_mem_mmio.sv
// Word RAM (combinational read, synchronous write) plus a small MMIO window
// holding an LED register and a compare-match timer with a W1C irq flag.
module data_mem_mmio #(
    parameter int unsigned DEPTH_WORDS = 64,
    parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000,
    parameter int unsigned LED_W       = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    data_mem_mmio_if.slave   bus,
    output logic [LED_W-1:0] led_o,
    output logic             irq_o
);
    localparam int unsigned AW = $clog2(DEPTH_WORDS);

    localparam logic [5:0] REG_LED    = 6'h00;
    localparam logic [5:0] REG_CTRL   = 6'h01;
    localparam logic [5:0] REG_COUNT  = 6'h02;
    localparam logic [5:0] REG_CMP    = 6'h03;
    localparam logic [5:0] REG_STATUS = 6'h04;

    logic [31:0]      mem_q [DEPTH_WORDS];
    logic [AW-1:0]    ram_idx;
    logic             mmio_sel;
    logic [5:0]       reg_sel;
    logic             wr_mmio;

    logic [LED_W-1:0] led_q,   led_d;
    logic             en_q,    en_d;
    logic             ar_q,    ar_d;
    logic [31:0]      count_q, count_d;
    logic [31:0]      cmp_q,   cmp_d;
    logic             match_q, match_d;

    logic unused_addr_lsb;
    assign unused_addr_lsb = ^bus.addr[1:0];

    assign mmio_sel = (bus.addr[31:8] == MMIO_BASE[31:8]);
    assign ram_idx  = bus.addr[AW+1:2];
    assign reg_sel  = bus.addr[7:2];
    assign wr_mmio  = bus.memwrite && mmio_sel;

    // RAM is deliberately not reset so data survives a core reset.
    always_ff @(posedge clk_i) begin
        if (bus.memwrite && !mmio_sel) begin
            mem_q[ram_idx] <= bus.writedata;
        end
    end

    always_comb begin
        led_d   = led_q;
        en_d    = en_q;
        ar_d    = ar_q;
        cmp_d   = cmp_q;
        count_d = count_q;
        match_d = match_q;

        if (wr_mmio && reg_sel == REG_LED) begin
            led_d = bus.writedata[LED_W-1:0];
        end
        if (wr_mmio && reg_sel == REG_CTRL) begin
            en_d = bus.writedata[0];
            ar_d = bus.writedata[1];
        end
        if (wr_mmio && reg_sel == REG_CMP) begin
            cmp_d = bus.writedata;
        end
        if (wr_mmio && reg_sel == REG_STATUS && bus.writedata[0]) begin
            match_d = 1'b0;
        end

        // A software COUNT write suppresses both increment and compare.
        if (wr_mmio && reg_sel == REG_COUNT) begin
            count_d = bus.writedata;
        end else if (en_q && count_q == cmp_q) begin
            match_d = 1'b1;
            count_d = ar_q ? 32'd0 : count_q + 32'd1;
        end else if (en_q) begin
            count_d = count_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            led_q   <= '0;
            en_q    <= 1'b0;
            ar_q    <= 1'b0;
            count_q <= 32'd0;
            cmp_q   <= 32'hFFFF_FFFF;
            match_q <= 1'b0;
        end else begin
            led_q   <= led_d;
            en_q    <= en_d;
            ar_q    <= ar_d;
            count_q <= count_d;
            cmp_q   <= cmp_d;
            match_q <= match_d;
        end
    end

    always_comb begin
        bus.readdata = 32'd0;
        if (mmio_sel) begin
            case (reg_sel)
                REG_LED:    bus.readdata = 32'(led_q);
                REG_CTRL:   bus.readdata = {30'd0, ar_q, en_q};
                REG_COUNT:  bus.readdata = count_q;
                REG_CMP:    bus.readdata = cmp_q;
                REG_STATUS: bus.readdata = {31'd0, match_q};
                default:    bus.readdata = 32'd0;
            endcase
        end else begin
            bus.readdata = mem_q[ram_idx];
        end
    end

    assign led_o = led_q;
    assign irq_o = match_q;
endmodule

// File: tb/tb_data_mem_mmio.sv
// Scoreboard bench for data_mem_mmio: stimulus pushes expected outputs from a
// behavioural model, a negedge monitor pops and compares them.
module tb_data_mem_mmio;
    logic       clk_i = 1'b0;
    logic       rst_i = 1'b0;
    logic [7:0] led_o;
    logic       irq_o;

    data_mem_mmio_if bus ();

    data_mem_mmio dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus),
        .led_o (led_o),
        .irq_o (irq_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int          id;
        bit          chk;
        bit          chk_rd;
        logic [31:0] rd;
        logic [7:0]  led;
        logic        irq;
    } exp_t;

    exp_t sbq[$];
    int   n_assert = 0;
    int   n_fail   = 0;
    int   step_id  = 0;

    // Reference model state
    bit          m_init = 0;
    logic [31:0] m_ram [64];
    bit          m_ram_ok [64];
    logic [7:0]  m_led;
    bit          m_en, m_ar, m_match;
    logic [31:0] m_count, m_cmp;

    function automatic bit is_mmio(input logic [31:0] a);
        return (a >> 8) == 32'h00FF_FF00;
    endfunction

    function automatic int ram_slot(input logic [31:0] a);
        return int'((a >> 2) % 64);
    endfunction

    task automatic model_read(input logic [31:0] a, output logic [31:0] rd, output bit ok);
        ok = m_init;
        rd = 32'd0;
        if (is_mmio(a)) begin
            case (a[7:0] & 8'hFC)
                8'h00: rd = {24'd0, m_led};
                8'h04: rd = {30'd0, m_ar, m_en};
                8'h08: rd = m_count;
                8'h0C: rd = m_cmp;
                8'h10: rd = {31'd0, m_match};
                default: rd = 32'd0;
            endcase
        end else begin
            ok = m_ram_ok[ram_slot(a)];
            rd = m_ram[ram_slot(a)];
        end
    endtask

    task automatic model_edge(input bit r, input bit we, input logic [31:0] a, input logic [31:0] wd);
        logic [7:0] off;
        bit         mm;
        bit         nmatch;
        logic [31:0] ncount;
        mm  = is_mmio(a);
        off = a[7:0] & 8'hFC;
        if (we && !mm) begin
            m_ram[ram_slot(a)]    = wd;
            m_ram_ok[ram_slot(a)] = 1;
        end
        if (r) begin
            m_init = 1;
            m_led = 0; m_en = 0; m_ar = 0; m_count = 0; m_cmp = 32'hFFFF_FFFF; m_match = 0;
            return;
        end
        if (!m_init) return;
        nmatch = m_match;
        ncount = m_count;
        if (we && mm && off == 8'h10 && wd[0]) nmatch = 0;
        if (we && mm && off == 8'h08) ncount = wd;
        else if (m_en && m_count == m_cmp) begin
            nmatch = 1;
            ncount = m_ar ? 32'd0 : m_count + 32'd1;
        end else if (m_en) ncount = m_count + 32'd1;
        if (we && mm && off == 8'h00) m_led = wd[7:0];
        if (we && mm && off == 8'h04) begin m_en = wd[0]; m_ar = wd[1]; end
        if (we && mm && off == 8'h0C) m_cmp = wd;
        m_match = nmatch;
        m_count = ncount;
    endtask

    task automatic step(input bit r, input bit we, input logic [31:0] a, input logic [31:0] wd);
        exp_t        e;
        logic [31:0] rd;
        bit          ok;
        @(posedge clk_i);
        #1;
        rst_i         = r;
        bus.memwrite  = we;
        bus.addr      = a;
        bus.writedata = wd;
        model_read(a, rd, ok);
        e.id     = step_id;
        e.chk    = m_init;
        e.chk_rd = ok;
        e.rd     = rd;
        e.led    = m_led;
        e.irq    = m_match;
        sbq.push_back(e);
        step_id++;
        model_edge(r, we, a, wd);
    endtask

    task automatic rd_(input logic [31:0] a);
        step(0, 0, a, 32'd0);
    endtask

    task automatic wr_(input logic [31:0] a, input logic [31:0] d);
        step(0, 1, a, d);
    endtask

    always @(negedge clk_i) begin
        if (sbq.size() != 0) begin
            exp_t e;
            e = sbq.pop_front();
            if (e.chk) begin
                n_assert++;
                if (led_o !== e.led) begin
                    n_fail++;
                    $display("FAIL led step %0d: got %h expected %h", e.id, led_o, e.led);
                end
                n_assert++;
                if (irq_o !== e.irq) begin
                    n_fail++;
                    $display("FAIL irq step %0d: got %b expected %b", e.id, irq_o, e.irq);
                end
            end
            if (e.chk_rd) begin
                n_assert++;
                if (bus.readdata !== e.rd) begin
                    n_fail++;
                    $display("FAIL readdata step %0d addr %h: got %h expected %h",
                             e.id, bus.addr, bus.readdata, e.rd);
                end
            end
        end
    end

    initial begin
        bus.memwrite  = 0;
        bus.addr      = 0;
        bus.writedata = 0;
        for (int i = 0; i < 64; i++) m_ram_ok[i] = 0;

        // 1 reset
        step(1, 0, 32'h0, 32'h0);
        rd_(32'hFFFF_000C);
        rd_(32'hFFFF_0008);
        rd_(32'hFFFF_0000);
        rd_(32'hFFFF_0010);

        // 2 RAM, aliasing, read-during-write
        wr_(32'h0000_0010, 32'h1111_1111);
        wr_(32'h0000_0010, 32'h1234_ABCD);
        rd_(32'h0000_0010);
        rd_(32'h0000_0110);
        wr_(32'h0000_00FC, 32'hDEAD_BEEF);
        rd_(32'h0001_00FC);

        // 3 timer with auto-reload
        wr_(32'hFFFF_000C, 32'd5);
        wr_(32'hFFFF_0004, 32'd3);
        for (int i = 0; i < 9; i++) rd_(32'hFFFF_0008);
        rd_(32'hFFFF_0010);

        // 4 W1C, then W1C every cycle across the next match edge
        wr_(32'hFFFF_0010, 32'd1);
        rd_(32'hFFFF_0010);
        for (int i = 0; i < 8; i++) wr_(32'hFFFF_0010, 32'd1);
        rd_(32'hFFFF_0010);
        wr_(32'hFFFF_0010, 32'd0);
        rd_(32'hFFFF_0010);

        // 5 wrap without match, COUNT write while running
        wr_(32'hFFFF_0004, 32'd0);
        wr_(32'hFFFF_0010, 32'd1);
        wr_(32'hFFFF_000C, 32'd3);
        wr_(32'hFFFF_0008, 32'hFFFF_FFFE);
        wr_(32'hFFFF_0004, 32'd1);
        for (int i = 0; i < 3; i++) rd_(32'hFFFF_0008);
        rd_(32'hFFFF_0010);
        wr_(32'hFFFF_0008, 32'h0000_0100);
        rd_(32'hFFFF_0008);

        // 6 reset mid-run
        wr_(32'hFFFF_0000, 32'hA5);
        wr_(32'hFFFF_000C, 32'd7);
        wr_(32'hFFFF_0008, 32'd6);
        rd_(32'hFFFF_0010);
        rd_(32'hFFFF_0010);
        rd_(32'hFFFF_0004);
        step(1, 0, 32'hFFFF_0000, 32'd0);
        rd_(32'hFFFF_0000);
        rd_(32'hFFFF_0004);
        rd_(32'hFFFF_0008);
        rd_(32'hFFFF_000C);
        rd_(32'hFFFF_0010);
        rd_(32'h0000_0010);

        // randomized mix
        for (int i = 0; i < 600; i++) begin
            int unsigned k;
            logic [31:0] a;
            logic [31:0] d;
            k = $urandom_range(0, 99);
            d = $urandom;
            if (k < 3) begin
                step(1, 0, 32'hFFFF_0008, 32'd0);
            end else if (k < 30) begin
                a = ($urandom & 32'h0FFF_FFFC) | 32'(k[1:0]);
                step(0, k[0], a, d);
            end else begin
                a = 32'hFFFF_0000 | 32'($urandom_range(0, 7) * 4) | 32'($urandom_range(0, 3));
                if (k > 96) a = 32'hFFFF_0000 | 32'($urandom_range(0, 255));
                if (a[7:0] >= 8'h08 && a[7:0] < 8'h10) d = 32'($urandom_range(0, 24));
                if (k >= 70) step(0, 0, a, d);
                else         step(0, 1, a, d);
            end
        end

        begin
            int guard;
            guard = 0;
            while (sbq.size() != 0 && guard < 20) begin
                @(posedge clk_i);
                guard++;
            end
            if (sbq.size() != 0) begin
                n_assert++;
                n_fail++;
                $display("FAIL drain: %0d entries left, expected 0", sbq.size());
            end
        end
        @(posedge clk_i);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
